// File: rtl/alu_issue_stage.sv
// Single-entry issue register in front of the ALU: x0 zeroing, immediate select, opcode legality check.
// Define ALU_ISSUE_FWD_EN to enable result bypass at capture and snooping of a held entry.

module alu_issue_operand (
    input  logic [4:0]  addr,
    input  logic [31:0] data,
    input  logic        fwd_valid,
    input  logic [4:0]  fwd_addr,
    input  logic [31:0] fwd_data,
    output logic [31:0] value
);
    logic fwd_hit;

    assign fwd_hit = fwd_valid && (fwd_addr != 5'd0) && (fwd_addr == addr);

    // x0 wins over everything; bypass can never target x0 anyway.
    always_comb begin
        value = data;
        if (addr == 5'd0)
            value = 32'h0;
        else if (fwd_hit)
            value = fwd_data;
    end
endmodule

module alu_issue_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        In_Valid,
    output logic        In_Ready,
    input  logic [31:0] Rs1_Data,
    input  logic [31:0] Rs2_Data,
    input  logic [31:0] Imm,
    input  logic [4:0]  Rs1_Addr,
    input  logic [4:0]  Rs2_Addr,
    input  logic [4:0]  Rd_Addr,
    input  logic        ALUSrc,
    input  logic [3:0]  ALU_Control_In,
    input  logic        Ex_Ready,
    input  logic        Flush,
    input  logic        Fwd_Valid,
    input  logic [4:0]  Fwd_Rd_Addr,
    input  logic [31:0] Fwd_Data,
    output logic        Out_Valid,
    output logic [31:0] ALU_In1,
    output logic [31:0] ALU_In2,
    output logic [3:0]  ALU_Control,
    output logic [4:0]  Out_Rd_Addr,
    output logic [31:0] Out_Store_Data,
    output logic        Out_Illegal
);
    localparam int NUM_SRC = 2;

    logic [NUM_SRC-1:0][4:0]  src_addr;
    logic [NUM_SRC-1:0][31:0] src_data;
    logic [NUM_SRC-1:0][31:0] src_val;
    logic                     fwd_v;
    logic [4:0]               fwd_a;
    logic [31:0]              fwd_d;
    logic                     capture;
    logic                     legal;

`ifdef ALU_ISSUE_FWD_EN
    logic [NUM_SRC-1:0][4:0] st_addr;
    logic                    st_alusrc;
    logic [NUM_SRC-1:0]      snoop_hit;

    assign fwd_v = Fwd_Valid;
    assign fwd_a = Fwd_Rd_Addr;
    assign fwd_d = Fwd_Data;
`else
    logic fwd_unused;

    assign fwd_v      = 1'b0;
    assign fwd_a      = 5'd0;
    assign fwd_d      = 32'h0;
    assign fwd_unused = ^{Fwd_Valid, Fwd_Rd_Addr, Fwd_Data};
`endif

    assign src_addr = {Rs2_Addr, Rs1_Addr};
    assign src_data = {Rs2_Data, Rs1_Data};

    alu_issue_operand u_op [NUM_SRC-1:0] (
        .addr      (src_addr),
        .data      (src_data),
        .fwd_valid (fwd_v),
        .fwd_addr  (fwd_a),
        .fwd_data  (fwd_d),
        .value     (src_val)
    );

    assign In_Ready = !Flush && (!Out_Valid || Ex_Ready);
    assign capture  = In_Valid && In_Ready;

    always_comb begin
        case (ALU_Control_In)
            4'b0000, 4'b0001, 4'b0010, 4'b0110: legal = 1'b1;
            default:                            legal = 1'b0;
        endcase
    end

`ifdef ALU_ISSUE_FWD_EN
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++)
            snoop_hit[i] = Fwd_Valid && (Fwd_Rd_Addr != 5'd0) && (Fwd_Rd_Addr == st_addr[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_addr   <= '0;
            st_alusrc <= 1'b0;
        end else if (capture) begin
            st_addr   <= src_addr;
            st_alusrc <= ALUSrc;
        end
    end
`endif

    // Flush beats capture, capture beats drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Out_Valid      <= 1'b0;
            ALU_In1        <= 32'h0;
            ALU_In2        <= 32'h0;
            ALU_Control    <= 4'b0000;
            Out_Rd_Addr    <= 5'd0;
            Out_Store_Data <= 32'h0;
            Out_Illegal    <= 1'b0;
        end else if (Flush) begin
            Out_Valid <= 1'b0;
        end else if (capture) begin
            Out_Valid      <= 1'b1;
            ALU_In1        <= src_val[0];
            ALU_In2        <= ALUSrc ? Imm : src_val[1];
            Out_Store_Data <= src_val[1];
            ALU_Control    <= legal ? ALU_Control_In : 4'b0000;
            Out_Illegal    <= !legal;
            Out_Rd_Addr    <= Rd_Addr;
        end else begin
            if (Ex_Ready)
                Out_Valid <= 1'b0;
`ifdef ALU_ISSUE_FWD_EN
            // A held entry picks up results that retire while it waits.
            if (Out_Valid) begin
                if (snoop_hit[0])
                    ALU_In1 <= Fwd_Data;
                if (snoop_hit[1]) begin
                    Out_Store_Data <= Fwd_Data;
                    if (!st_alusrc)
                        ALU_In2 <= Fwd_Data;
                end
            end
`endif
        end
    end
endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed checks for alu_issue_stage; fills in bypass/snoop expectations when ALU_ISSUE_FWD_EN is set.

module tb_alu_issue_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        In_Valid, In_Ready;
    logic [31:0] Rs1_Data, Rs2_Data, Imm;
    logic [4:0]  Rs1_Addr, Rs2_Addr, Rd_Addr;
    logic        ALUSrc;
    logic [3:0]  ALU_Control_In;
    logic        Ex_Ready, Flush;
    logic        Fwd_Valid;
    logic [4:0]  Fwd_Rd_Addr;
    logic [31:0] Fwd_Data;
    logic        Out_Valid;
    logic [31:0] ALU_In1, ALU_In2;
    logic [3:0]  ALU_Control;
    logic [4:0]  Out_Rd_Addr;
    logic [31:0] Out_Store_Data;
    logic        Out_Illegal;

    int total = 0;
    int fails = 0;

    alu_issue_stage dut (
        .clk(clk), .rst_n(rst_n), .In_Valid(In_Valid), .In_Ready(In_Ready),
        .Rs1_Data(Rs1_Data), .Rs2_Data(Rs2_Data), .Imm(Imm),
        .Rs1_Addr(Rs1_Addr), .Rs2_Addr(Rs2_Addr), .Rd_Addr(Rd_Addr),
        .ALUSrc(ALUSrc), .ALU_Control_In(ALU_Control_In),
        .Ex_Ready(Ex_Ready), .Flush(Flush),
        .Fwd_Valid(Fwd_Valid), .Fwd_Rd_Addr(Fwd_Rd_Addr), .Fwd_Data(Fwd_Data),
        .Out_Valid(Out_Valid), .ALU_In1(ALU_In1), .ALU_In2(ALU_In2),
        .ALU_Control(ALU_Control), .Out_Rd_Addr(Out_Rd_Addr),
        .Out_Store_Data(Out_Store_Data), .Out_Illegal(Out_Illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, {31'b0, Out_Valid}, 32'h0);
        chk({tag, "_in1"}, ALU_In1, 32'h0);
        chk({tag, "_in2"}, ALU_In2, 32'h0);
        chk({tag, "_store"}, Out_Store_Data, 32'h0);
        chk({tag, "_ctrl"}, {28'b0, ALU_Control}, 32'h0);
        chk({tag, "_rd"}, {27'b0, Out_Rd_Addr}, 32'h0);
        chk({tag, "_illegal"}, {31'b0, Out_Illegal}, 32'h0);
    endtask

    task automatic issue(input logic [4:0] a1, input logic [31:0] d1, input logic [4:0] a2,
                         input logic [31:0] d2, input logic src, input logic [31:0] imm,
                         input logic [3:0] ctrl, input logic [4:0] rd);
        In_Valid = 1'b1;
        Rs1_Addr = a1; Rs1_Data = d1; Rs2_Addr = a2; Rs2_Data = d2;
        ALUSrc = src; Imm = imm; ALU_Control_In = ctrl; Rd_Addr = rd;
    endtask

    initial begin
        rst_n = 1'b0; In_Valid = 1'b0; Ex_Ready = 1'b1; Flush = 1'b0;
        Rs1_Data = '0; Rs2_Data = '0; Imm = '0; Rs1_Addr = '0; Rs2_Addr = '0; Rd_Addr = '0;
        ALUSrc = 1'b0; ALU_Control_In = '0;
        Fwd_Valid = 1'b0; Fwd_Rd_Addr = '0; Fwd_Data = '0;

        #3;
        chk_all_zero("reset");
        chk("reset_in_ready", {31'b0, In_Ready}, 32'h1);
        #9 rst_n = 1'b1;

        // basic capture
        issue(5'd1, 32'd5, 5'd2, 32'd7, 1'b0, 32'h0, 4'b0010, 5'd4);
        step();
        chk("cap_valid", {31'b0, Out_Valid}, 32'h1);
        chk("cap_in1", ALU_In1, 32'd5);
        chk("cap_in2", ALU_In2, 32'd7);
        chk("cap_ctrl", {28'b0, ALU_Control}, 32'h2);
        chk("cap_rd", {27'b0, Out_Rd_Addr}, 32'd4);
        chk("cap_store", Out_Store_Data, 32'd7);
        chk("cap_illegal", {31'b0, Out_Illegal}, 32'h0);

        // back-to-back: x0 on rs1, immediate on In2, forward to x0 ignored
        issue(5'd0, 32'd9, 5'd2, 32'd7, 1'b1, 32'hFFFF_FFFC, 4'b0110, 5'd8);
        Fwd_Valid = 1'b1; Fwd_Rd_Addr = 5'd0; Fwd_Data = 32'h55;
        step();
        chk("x0_valid", {31'b0, Out_Valid}, 32'h1);
        chk("x0_in1", ALU_In1, 32'h0);
        chk("imm_in2", ALU_In2, 32'hFFFF_FFFC);
        chk("imm_store", Out_Store_Data, 32'd7);
        chk("imm_ctrl", {28'b0, ALU_Control}, 32'h6);
        Fwd_Valid = 1'b0;

        // illegal opcode, x0 on rs2
        issue(5'd1, 32'h11, 5'd0, 32'h22, 1'b0, 32'h0, 4'b0111, 5'd9);
        step();
        chk("ill_flag", {31'b0, Out_Illegal}, 32'h1);
        chk("ill_ctrl", {28'b0, ALU_Control}, 32'h0);
        chk("ill_in2_x0", ALU_In2, 32'h0);
        chk("ill_store_x0", Out_Store_Data, 32'h0);

        issue(5'd1, 32'h11, 5'd5, 32'h33, 1'b0, 32'h0, 4'b0110, 5'd9);
        step();
        chk("legal_flag", {31'b0, Out_Illegal}, 32'h0);
        chk("legal_ctrl", {28'b0, ALU_Control}, 32'h6);
        chk("legal_in2", ALU_In2, 32'h33);

        // drain
        In_Valid = 1'b0;
        step();
        chk("drain_valid", {31'b0, Out_Valid}, 32'h0);

        // stall with held entry, then snoop
        Ex_Ready = 1'b0;
        issue(5'd3, 32'h100, 5'd6, 32'h200, 1'b0, 32'h0, 4'b0001, 5'd10);
        step();
        chk("stall_valid", {31'b0, Out_Valid}, 32'h1);
        chk("stall_in1", ALU_In1, 32'h100);
        chk("stall_ready", {31'b0, In_Ready}, 32'h0);
        issue(5'd3, 32'h999, 5'd6, 32'h888, 1'b0, 32'h0, 4'b0010, 5'd11);
        Fwd_Valid = 1'b1; Fwd_Rd_Addr = 5'd3; Fwd_Data = 32'hDEAD;
        step();
        chk("stall_ready2", {31'b0, In_Ready}, 32'h0);
        chk("stall_valid2", {31'b0, Out_Valid}, 32'h1);
        chk("stall_rd_hold", {27'b0, Out_Rd_Addr}, 32'd10);
        chk("stall_in2_hold", ALU_In2, 32'h200);
`ifdef ALU_ISSUE_FWD_EN
        chk("snoop_in1", ALU_In1, 32'hDEAD);
`else
        chk("nosnoop_in1", ALU_In1, 32'h100);
`endif
        Fwd_Rd_Addr = 5'd6; Fwd_Data = 32'hBEEF;
        step();
`ifdef ALU_ISSUE_FWD_EN
        chk("snoop_in2", ALU_In2, 32'hBEEF);
        chk("snoop_store", Out_Store_Data, 32'hBEEF);
`else
        chk("nosnoop_in2", ALU_In2, 32'h200);
        chk("nosnoop_store", Out_Store_Data, 32'h200);
`endif
        Fwd_Valid = 1'b0;

        // flush with In_Valid and a held entry
        Flush = 1'b1;
        #1;
        chk("flush_ready", {31'b0, In_Ready}, 32'h0);
        step();
        chk("flush_valid", {31'b0, Out_Valid}, 32'h0);
        Flush = 1'b0; In_Valid = 1'b0;
        step();
        chk("flush_no_entry", {31'b0, Out_Valid}, 32'h0);
        chk("flush_ready_after", {31'b0, In_Ready}, 32'h1);

        // bypass at capture, both sources matching
        Ex_Ready = 1'b1;
        issue(5'd7, 32'h1, 5'd7, 32'h2, 1'b0, 32'h0, 4'b0000, 5'd12);
        Fwd_Valid = 1'b1; Fwd_Rd_Addr = 5'd7; Fwd_Data = 32'hABC;
        step();
`ifdef ALU_ISSUE_FWD_EN
        chk("byp_in1", ALU_In1, 32'hABC);
        chk("byp_in2", ALU_In2, 32'hABC);
`else
        chk("nobyp_in1", ALU_In1, 32'h1);
        chk("nobyp_in2", ALU_In2, 32'h2);
`endif
        Fwd_Valid = 1'b0;

        // reset mid-stall
        Ex_Ready = 1'b0;
        issue(5'd1, 32'h77, 5'd2, 32'h66, 1'b0, 32'h0, 4'b0010, 5'd13);
        step();
        chk("pre_rst_valid", {31'b0, Out_Valid}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        #2 rst_n = 1'b1;
        issue(5'd1, 32'h42, 5'd2, 32'h43, 1'b0, 32'h0, 4'b0000, 5'd14);
        step();
        chk("post_rst_valid", {31'b0, Out_Valid}, 32'h1);
        chk("post_rst_in1", ALU_In1, 32'h42);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
